// File: rtl/note_memory_player_pkg.sv
// Shared definitions for the note memory player: note word layout, tone constants, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents: DATA_WIDTH of a note word, NOTE/OCTAVE field bounds, the seven mid-octave
// half-periods at 100 MHz, the player state encoding and the note-word decode helpers.
package note_memory_player_pkg;

    localparam int DATA_WIDTH = 10;
    localparam int NOTE_LSB   = 0;
    localparam int NOTE_MSB   = 6;
    localparam int OCTAVE_LSB = 7;
    localparam int OCTAVE_MSB = 9;
    localparam int HP_WIDTH   = 20;

    // Mid-octave half-periods in 100 MHz clk cycles
    localparam logic [HP_WIDTH-1:0] HP_C = 20'd191113;
    localparam logic [HP_WIDTH-1:0] HP_D = 20'd170262;
    localparam logic [HP_WIDTH-1:0] HP_E = 20'd151686;
    localparam logic [HP_WIDTH-1:0] HP_F = 20'd143172;
    localparam logic [HP_WIDTH-1:0] HP_G = 20'd127551;
    localparam logic [HP_WIDTH-1:0] HP_A = 20'd113636;
    localparam logic [HP_WIDTH-1:0] HP_B = 20'd101239;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REWIND,
        ST_REQ,
        ST_WAIT,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    // Lowest set note bit wins (two's-complement isolate-lowest-one trick)
    function automatic logic [6:0] pick_note(input logic [6:0] bits);
        return bits & (~bits + 7'd1);
    endfunction

    // Octave one-hot {high,mid,low}; high beats mid beats low, nothing set means mid
    function automatic logic [2:0] pick_octave(input logic [2:0] bits);
        logic [2:0] oct;
        oct = 3'b010;
        if (bits[2])      oct = 3'b100;
        else if (bits[1]) oct = 3'b010;
        else if (bits[0]) oct = 3'b001;
        return oct;
    endfunction

    // Half-period for a decoded note/octave; rest (no note bit) yields 0
    function automatic logic [HP_WIDTH-1:0] half_period(input logic [6:0]  note_oh,
                                                        input logic [2:0]  oct_oh,
                                                        input int unsigned shift);
        logic [HP_WIDTH-1:0] hp;
        hp = '0;
        case (note_oh)
            7'b0000001: hp = HP_C;
            7'b0000010: hp = HP_D;
            7'b0000100: hp = HP_E;
            7'b0001000: hp = HP_F;
            7'b0010000: hp = HP_G;
            7'b0100000: hp = HP_A;
            7'b1000000: hp = HP_B;
            default:    hp = '0;
        endcase
        if (oct_oh[2])      hp = hp >> 1;
        else if (oct_oh[0]) hp = hp << 1;
        return hp >> shift;
    endfunction

endpackage

// File: rtl/note_memory_player_tone_generator.sv
// Square-wave generator: toggles o_buzzer every i_half_period cycles while enabled.
// Latency: first toggle i_half_period cycles after i_enable rises; clears one edge after drop.
// Backpressure: none; free-running while enabled.
//
// Ports: clk, rst_n (sync, active-low), i_half_period, i_enable, o_buzzer.
module note_memory_player_tone_generator
    import note_memory_player_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HP_WIDTH-1:0] i_half_period,
    input  logic                i_enable,
    output logic                o_buzzer
);

    logic [HP_WIDTH-1:0] r_cnt;
    logic                r_buzzer;

    // Holding the counter at zero while disabled gives a clean reload on every note start
    always_ff @(posedge clk) begin
        if (!rst_n || !i_enable) begin
            r_cnt    <= '0;
            r_buzzer <= 1'b0;
        end else if (r_cnt == i_half_period - 20'd1) begin
            r_cnt    <= '0;
            r_buzzer <= ~r_buzzer;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    assign o_buzzer = r_buzzer;

endmodule

// File: rtl/note_memory_player.sv
// Note memory player: reads note words from a note memory and sounds each one on the buzzer.
// Latency: start -> rewind 1 cycle, read 1 cycle, wait 1 cycle, then note plays NOTE_CYCLES + GAP_CYCLES.
// Backpressure: one outstanding read; memory not ready on a read means end of song.
//
// Ports: clk, rst_n (sync, active-low), start/stop pulses, mem_data/mem_ready from memory,
// mem_read_en/mem_read_rst to memory, buzzer, playing, song_done, note_led, octave_led.
// Build option: define PLAYER_LOOP_EN to rewind and replay endlessly at end of song.
module note_memory_player
    import note_memory_player_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES      = 50_000_000,
    parameter int unsigned GAP_CYCLES       = 5_000_000,
    parameter int unsigned TONE_SCALE_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready,
    output logic                  mem_read_en,
    output logic                  mem_read_rst,
    output logic                  buzzer,
    output logic                  playing,
    output logic                  song_done,
    output logic [6:0]            note_led,
    output logic [2:0]            octave_led
);

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

    state_t              r_state;
    logic [31:0]         r_cnt;
    logic                r_read_en;
    logic                r_read_rst;
    logic                r_playing;
    logic                r_song_done;
    logic [6:0]          r_note;
    logic [2:0]          r_oct;
    logic [HP_WIDTH-1:0] r_half;
    logic                r_tone_en;

    logic [6:0]          w_note_oh;
    logic [2:0]          w_oct_oh;
    logic [HP_WIDTH-1:0] w_half;
    logic                w_play_end;
    logic                w_tone_en;

    assign w_note_oh = pick_note(mem_data[NOTE_MSB:NOTE_LSB]);
    assign w_oct_oh  = pick_octave(mem_data[OCTAVE_MSB:OCTAVE_LSB]);
    assign w_half    = half_period(w_note_oh, w_oct_oh, TONE_SCALE_SHIFT);

    // Gate the tone enable on the same cycle the FSM leaves PLAY (or sees stop) so the
    // buzzer is already low on the first GAP/IDLE cycle instead of one cycle later.
    assign w_play_end = (r_state == ST_PLAY) && (r_cnt == NOTE_LAST);
    assign w_tone_en  = r_tone_en && !stop && !w_play_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_read_en   <= 1'b0;
            r_read_rst  <= 1'b0;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
            r_note      <= '0;
            r_oct       <= '0;
            r_half      <= '0;
            r_tone_en   <= 1'b0;
        end else begin
            // Pulse outputs default low; a transition below raises them for exactly one cycle
            r_read_en   <= 1'b0;
            r_read_rst  <= 1'b0;
            r_song_done <= 1'b0;
            if (stop) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_playing <= 1'b0;
                r_note    <= '0;
                r_oct     <= '0;
                r_tone_en <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        r_state <= ST_IDLE;
                        if (start) begin
                            r_state    <= ST_REWIND;
                            r_read_rst <= 1'b1;
                            r_playing  <= 1'b1;
                        end
                    end
                    ST_REWIND: begin
                        r_state   <= ST_REQ;
                        r_read_en <= 1'b1;
                    end
                    ST_REQ: begin
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (mem_ready) begin
                            r_state   <= ST_PLAY;
                            r_cnt     <= '0;
                            r_note    <= w_note_oh;
                            r_oct     <= w_oct_oh;
                            r_half    <= w_half;
                            r_tone_en <= |w_note_oh;
                        end else begin
                            r_song_done <= 1'b1;
`ifdef PLAYER_LOOP_EN
                            r_state    <= ST_REWIND;
                            r_read_rst <= 1'b1;
`else
                            r_state   <= ST_DONE;
                            r_playing <= 1'b0;
                            r_oct     <= '0;
`endif
                        end
                    end
                    ST_PLAY: begin
                        if (w_play_end) begin
                            r_state   <= ST_GAP;
                            r_cnt     <= '0;
                            r_note    <= '0;
                            r_tone_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    ST_GAP: begin
                        if (r_cnt == GAP_LAST) begin
                            r_state   <= ST_REQ;
                            r_cnt     <= '0;
                            r_read_en <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    note_memory_player_tone_generator u_tone_generator (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_half_period (r_half),
        .i_enable      (w_tone_en),
        .o_buzzer      (buzzer)
    );

    assign mem_read_en  = r_read_en;
    assign mem_read_rst = r_read_rst;
    assign playing      = r_playing;
    assign song_done    = r_song_done;
    assign note_led     = r_note;
    assign octave_led   = r_oct;

endmodule
